wb_cmd_master: RTL and testbench

WB_CMD_MASTER -- requirements
Module: wb_cmd_master

---
 rtl/wb_master_pkg.sv | 20 ++
 rtl/wb_cmd_master.sv | 133 +++++++++++++
 tb/tb_wb_cmd_master.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/wb_master_pkg.sv
// ============================================================================
// Module   : wb_master_pkg
// Purpose  : State encoding and default timeout for the Wishbone command master.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_master_pkg;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/wb_cmd_master.sv
// ============================================================================
// Module   : wb_cmd_master
// Purpose  : Single-beat Wishbone classic master driven by a valid/ready
//            command stream, returning read data or a timeout response.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_cmd_master
  import wb_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_data,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_timeout,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  output logic [3:0]  o_wb_sel,
  input  logic        i_wb_ack,
  input  logic [31:0] i_wb_data,
  output logic        busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_MAX = CNT_W'(TIMEOUT_CYCLES);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [3:0]        sel_q, sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic [CNT_W-1:0]  cnt_inc;

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d       = state_q;
    we_d          = we_q;
    addr_d        = addr_q;
    data_d        = data_q;
    sel_d         = sel_q;
    cnt_d         = cnt_q;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d = ST_BUS;
          we_d    = cmd_we;
          addr_d  = cmd_addr;
          data_d  = cmd_data;
          sel_d   = cmd_sel;
          cnt_d   = '0;
        end
      end
      ST_BUS: begin
        // Ack wins even on the edge where the counter would expire.
        if (i_wb_ack) begin
          state_d       = ST_RESP;
          rsp_data_d    = we_q ? 32'h0 : i_wb_data;
          rsp_timeout_d = 1'b0;
        end else if (cnt_inc == TIMEOUT_MAX) begin
          state_d       = ST_RESP;
          cnt_d         = cnt_inc;
          rsp_data_d    = 32'h0;
          rsp_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      we_q          <= 1'b0;
      addr_q        <= 32'h0;
      data_q        <= 32'h0;
      sel_q         <= 4'h0;
      cnt_q         <= '0;
      rsp_data_q    <= 32'h0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      sel_q         <= sel_d;
      cnt_q         <= cnt_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // Bus strobes decode straight from state so an async reset drops them at once.
  assign cmd_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign rsp_valid   = (state_q == ST_RESP);
  assign o_wb_cyc    = (state_q == ST_BUS);
  assign o_wb_stb    = (state_q == ST_BUS);
  assign o_wb_we     = we_q;
  assign o_wb_addr   = addr_q;
  assign o_wb_data   = data_q;
  assign o_wb_sel    = sel_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_cmd_master.sv
// ============================================================================
// Module   : tb_wb_cmd_master
// Purpose  : Directed and random transactions against a per-transaction model
//            of expected bus length, response data and timeout flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_cmd_master;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_addr, cmd_data;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_data;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [31:0] o_wb_addr, o_wb_data;
  logic [3:0]  o_wb_sel;
  logic        i_wb_ack;
  logic [31:0] i_wb_data;
  logic        busy;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] last_rsp;

  wb_cmd_master #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_timeout(rsp_timeout),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
    .i_wb_ack(i_wb_ack), .i_wb_data(i_wb_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // d = number of BUS edges without ack before the slave acks (d >= T: never).
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] sel, input int d, input logic [31:0] rdata,
                         input int hold, input bit keep_valid, input bit stray);
    int          cyc_cnt;
    int          exp_cycles;
    bit          exp_to;
    logic [31:0] exp_data;
    exp_to     = (d >= T);
    exp_cycles = exp_to ? T : d + 1;
    exp_data   = (exp_to || we) ? 32'h0 : rdata;

    chk1("cmd_ready_idle", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_data = data; cmd_sel = sel;
    step();
    if (!keep_valid) cmd_valid = 1'b0;
    cmd_we = ~we; cmd_addr = ~addr; cmd_data = ~data; cmd_sel = ~sel;
    chk1("busy_bus", busy, 1'b1);
    chk1("cmd_ready_bus", cmd_ready, 1'b0);

    cyc_cnt = 0;
    for (int k = 0; k < 100 && o_wb_cyc; k++) begin
      chk1("wb_stb", o_wb_stb, 1'b1);
      chk1("wb_we", o_wb_we, we);
      chk32("wb_addr", o_wb_addr, addr);
      chk32("wb_data", o_wb_data, data);
      chk32("wb_sel", 32'(o_wb_sel), 32'(sel));
      chk1("rsp_valid_in_bus", rsp_valid, 1'b0);
      cyc_cnt++;
      i_wb_ack  = (k == d);
      i_wb_data = (k == d) ? rdata : $urandom();
      step();
      i_wb_ack = 1'b0;
    end
    chk1("wb_cyc_released", o_wb_cyc, 1'b0);
    chk1("wb_stb_released", o_wb_stb, 1'b0);
    chk32("bus_cycles", cyc_cnt, exp_cycles);

    for (int h = 0; h < hold; h++) begin
      chk1("rsp_valid_hold", rsp_valid, 1'b1);
      chk32("rsp_data_hold", rsp_data, exp_data);
      chk1("rsp_timeout_hold", rsp_timeout, exp_to);
      chk1("cmd_ready_resp", cmd_ready, 1'b0);
      chk1("wb_cyc_resp", o_wb_cyc, 1'b0);
      if (stray) begin
        i_wb_ack  = 1'b1;
        i_wb_data = $urandom();
      end
      step();
      i_wb_ack = 1'b0;
    end
    chk1("rsp_valid", rsp_valid, 1'b1);
    chk32("rsp_data", rsp_data, exp_data);
    chk1("rsp_timeout", rsp_timeout, exp_to);
    chk1("cmd_ready_before_rsp_hs", cmd_ready, 1'b0);

    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk1("rsp_valid_after_hs", rsp_valid, 1'b0);
    chk1("cmd_ready_after_hs", cmd_ready, 1'b1);
    chk1("busy_after_hs", busy, 1'b0);
    if (keep_valid) cmd_valid = 1'b0;
    last_rsp = exp_data;
  endtask

  task automatic idle_stray(input int n);
    for (int i = 0; i < n; i++) begin
      i_wb_ack  = 1'b1;
      i_wb_data = $urandom();
      step();
      chk1("idle_stray_busy", busy, 1'b0);
      chk1("idle_stray_cyc", o_wb_cyc, 1'b0);
      chk1("idle_stray_rsp_valid", rsp_valid, 1'b0);
      chk32("idle_stray_rsp_data", rsp_data, last_rsp);
    end
    i_wb_ack = 1'b0;
  endtask

  initial begin
    logic        r_we;
    logic [3:0]  r_sel;
    logic [31:0] r_addr, r_data, r_rdata;
    int          r_d, r_hold;

    reset_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 32'h0; cmd_data = 32'h0;
    cmd_sel = 4'h0; rsp_ready = 1'b0; i_wb_ack = 1'b0; i_wb_data = 32'h0;
    last_rsp = 32'h0;
    #2;
    chk1("rst_cyc", o_wb_cyc, 1'b0);
    chk1("rst_stb", o_wb_stb, 1'b0);
    chk1("rst_we", o_wb_we, 1'b0);
    chk32("rst_addr", o_wb_addr, 32'h0);
    chk32("rst_data", o_wb_data, 32'h0);
    chk32("rst_sel", 32'(o_wb_sel), 32'h0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk32("rst_rsp_data", rsp_data, 32'h0);
    chk1("rst_rsp_timeout", rsp_timeout, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    repeat (2) step();
    reset_n = 1'b1;
    step();
    chk1("post_rst_cmd_ready", cmd_ready, 1'b1);

    // Write, ack after two wait cycles
    run_txn(1'b1, 32'h3000_0000, 32'h0000_000F, 4'hF, 2, 32'h1234_5678, 1, 1'b0, 1'b0);
    // Read, zero-wait ack
    run_txn(1'b0, 32'h3000_0004, 32'h5555_AAAA, 4'hF, 0, 32'hA5A5_0001, 1, 1'b0, 1'b0);
    // Read with no ack: timeout
    run_txn(1'b0, 32'h3000_0008, 32'h0, 4'hF, T, 32'hDEAD_BEEF, 1, 1'b0, 1'b0);
    // Ack on the very edge the counter would expire
    run_txn(1'b0, 32'h3000_000C, 32'h0, 4'h3, T - 1, 32'h0BAD_F00D, 1, 1'b0, 1'b0);
    // Response back-pressure with cmd_valid held and stray acks in RESP
    run_txn(1'b0, 32'h3000_0010, 32'h0, 4'hC, 1, 32'hCAFE_0001, 5, 1'b1, 1'b1);
    idle_stray(3);

    // Reset in the middle of a bus cycle
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h4000_0000; cmd_data = 32'h0; cmd_sel = 4'hF;
    step();
    cmd_valid = 1'b0;
    repeat (2) step();
    chk1("mid_bus_cyc", o_wb_cyc, 1'b1);
    reset_n = 1'b0;
    #1;
    chk1("async_rst_cyc", o_wb_cyc, 1'b0);
    chk1("async_rst_stb", o_wb_stb, 1'b0);
    chk1("async_rst_rsp_valid", rsp_valid, 1'b0);
    chk1("async_rst_busy", busy, 1'b0);
    chk32("async_rst_addr", o_wb_addr, 32'h0);
    repeat (2) step();
    reset_n = 1'b1;
    step();
    chk1("post_abort_rsp_valid", rsp_valid, 1'b0);
    chk1("post_abort_cmd_ready", cmd_ready, 1'b1);
    last_rsp = 32'h0;
    chk32("post_abort_rsp_data", rsp_data, last_rsp);
    run_txn(1'b0, 32'h4000_0004, 32'h0, 4'hF, 1, 32'h7777_1234, 1, 1'b0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      r_we    = 1'($urandom_range(0, 1));
      r_addr  = $urandom();
      r_data  = $urandom();
      r_sel   = 4'($urandom());
      r_d     = int'($urandom_range(0, T + 2));
      r_rdata = $urandom();
      r_hold  = int'($urandom_range(0, 3));
      run_txn(r_we, r_addr, r_data, r_sel, r_d, r_rdata, r_hold, 1'b0, 1'($urandom_range(0, 1)));
      if ((i % 4) == 3) idle_stray(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
